// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared MEM/WB definitions: writeback select encodings, default widths, payload layout
package mem_wb_pkg;
    localparam int DATAWIDTH_DEF = 32;
    localparam int REGINDEX_DEF  = 5;
    localparam int WB_ALU = 0;
    localparam int WB_MEM = 1;
    localparam int WB_PC4 = 2;
    typedef struct packed {
        logic [DATAWIDTH_DEF-1:0] mem;
        logic [DATAWIDTH_DEF-1:0] alu;
        logic [DATAWIDTH_DEF-1:0] pc4;
        logic [REGINDEX_DEF-1:0]  rd;
        logic                     regwrite;
        logic [1:0]               wbsel;
    } mem_wb_payload_t;
endpackage

// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer: generic valid/ready stage over a W-bit payload, optional one-entry skid, sync flush
// Ports: clk, rst (sync, active-high), flush; in_valid/in_ready/in_data upstream;
//        out_valid/out_ready/out_data downstream (out_data is the head entry).
module pipe_skid_buffer #(
    parameter int W    = 8,
    parameter int SKID = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         acc;
    logic         pop;

    assign acc       = in_valid & in_ready;
    assign pop       = m_valid & out_ready;
    assign out_valid = m_valid;
    assign out_data  = m_data;

    if (SKID != 0) begin : g_skid
        logic         s_valid;
        logic [W-1:0] s_data;
        // in_ready comes straight from the skid valid flop, so no path from out_ready
        assign in_ready = !s_valid;
        always_ff @(posedge clk) begin
            if (rst) begin
                m_valid <= 1'b0;
                s_valid <= 1'b0;
                m_data  <= '0;
                s_data  <= '0;
            end else if (flush) begin
                m_valid <= 1'b0;
                s_valid <= 1'b0;
            end else if (pop) begin
                if (s_valid) begin
                    m_data  <= s_data;
                    s_valid <= 1'b0;
                end else if (acc) begin
                    m_data <= in_data;
                end else begin
                    m_valid <= 1'b0;
                end
            end else if (acc) begin
                if (!m_valid) begin
                    m_data  <= in_data;
                    m_valid <= 1'b1;
                end else begin
                    s_data  <= in_data;
                    s_valid <= 1'b1;
                end
            end
        end
    end else begin : g_reg
        assign in_ready = out_ready | !m_valid;
        always_ff @(posedge clk) begin
            if (rst) begin
                m_valid <= 1'b0;
                m_data  <= '0;
            end else if (flush) begin
                m_valid <= 1'b0;
            end else if (acc) begin
                m_data  <= in_data;
                m_valid <= 1'b1;
            end else if (pop) begin
                m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/mem_wb_skid_stage.sv
// mem_wb_skid_stage: elastic MEM/WB stage with writeback mux, register-file write enable and forwarding valid
// Ports: clk, rst (sync, active-high), flush; in_valid/in_ready plus MEM payload inputs
//        (DataMEM_in, DataALU_in, PC4_in, regdindex_in, regwrite_in, WBsel_in);
//        out_valid/out_ready; wb_data, regdindex_out, wb_we, fwd_valid from the head entry.
module mem_wb_skid_stage
    import mem_wb_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF,
    parameter int REGINDEX  = REGINDEX_DEF,
    parameter int WBSELW    = 2,
    parameter int SKID      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] DataMEM_in,
    input  logic [DATAWIDTH-1:0] DataALU_in,
    input  logic [DATAWIDTH-1:0] PC4_in,
    input  logic [REGINDEX-1:0]  regdindex_in,
    input  logic                 regwrite_in,
    input  logic [WBSELW-1:0]    WBsel_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] wb_data,
    output logic [REGINDEX-1:0]  regdindex_out,
    output logic                 wb_we,
    output logic                 fwd_valid
);
    // Same field order as mem_wb_payload_t, sized by this instance's parameters
    typedef struct packed {
        logic [DATAWIDTH-1:0] mem;
        logic [DATAWIDTH-1:0] alu;
        logic [DATAWIDTH-1:0] pc4;
        logic [REGINDEX-1:0]  rd;
        logic                 regwrite;
        logic [WBSELW-1:0]    wbsel;
    } payload_t;

    payload_t in_p;
    payload_t head;

    assign in_p = {DataMEM_in, DataALU_in, PC4_in, regdindex_in, regwrite_in, WBsel_in};

    pipe_skid_buffer #(.W($bits(payload_t)), .SKID(SKID)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head)
    );

    always_comb begin
        wb_data = (head.wbsel == WBSELW'(WB_ALU)) ? head.alu :
                  (head.wbsel == WBSELW'(WB_MEM)) ? head.mem :
                  (head.wbsel == WBSELW'(WB_PC4)) ? head.pc4 : '0;
    end

    assign regdindex_out = head.rd;
    // x0 is hardwired, so a write to it is never a real result or forwarding source
    assign wb_we     = out_valid & head.regwrite & (head.rd != '0);
    assign fwd_valid = wb_we;
endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// tb_mem_wb_skid_stage: directed checks of the SKID=1 and SKID=0 builds of mem_wb_skid_stage
module tb_mem_wb_skid_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0, regwrite = 1'b0;
    logic [31:0] mem = '0, alu = '0, pc4 = '0;
    logic [4:0]  rd = '0;
    logic [1:0]  wbsel = '0;
    logic        in_ready, out_valid, wb_we, fwd_valid;
    logic [31:0] wb_data;
    logic [4:0]  rd_out;
    logic        z_in_valid = 1'b0, z_out_ready = 1'b0;
    logic [31:0] z_alu = '0;
    logic        z_in_ready, z_out_valid, z_wb_we, z_fwd_valid;
    logic [31:0] z_wb_data;
    logic [4:0]  z_rd_out;
    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    mem_wb_skid_stage #(.SKID(1)) u1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .DataMEM_in(mem), .DataALU_in(alu), .PC4_in(pc4), .regdindex_in(rd),
        .regwrite_in(regwrite), .WBsel_in(wbsel), .out_valid(out_valid), .out_ready(out_ready),
        .wb_data(wb_data), .regdindex_out(rd_out), .wb_we(wb_we), .fwd_valid(fwd_valid)
    );

    mem_wb_skid_stage #(.SKID(0)) u0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(z_in_valid), .in_ready(z_in_ready),
        .DataMEM_in(32'h0), .DataALU_in(z_alu), .PC4_in(32'h0), .regdindex_in(5'd1),
        .regwrite_in(1'b1), .WBsel_in(2'd0), .out_valid(z_out_valid), .out_ready(z_out_ready),
        .wb_data(z_wb_data), .regdindex_out(z_rd_out), .wb_we(z_wb_we), .fwd_valid(z_fwd_valid)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] m, input logic [31:0] a, input logic [31:0] p,
                         input logic [4:0] r, input logic w, input logic [1:0] s);
        in_valid = 1'b1; mem = m; alu = a; pc4 = p; rd = r; regwrite = w; wbsel = s;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
        total++; if (wb_we !== 1'b0 || fwd_valid !== 1'b0) $display("FAIL reset_we: got %b/%b want 0/0", wb_we, fwd_valid); else passed++;
        total++; if (wb_data !== 32'h0) $display("FAIL reset_wb_data: got %h want 0", wb_data); else passed++;
        total++; if (z_out_valid !== 1'b0) $display("FAIL reset_z_out_valid: got %b want 0", z_out_valid); else passed++;
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(32'h0, 32'h10 + i, 32'h0, 5'(i + 1), 1'b1, 2'd0);
            step();
            total++; if (out_valid !== 1'b1 || wb_data !== 32'h10 + i) $display("FAIL stream_%0d: got v=%b d=%h want v=1 d=%h", i, out_valid, wb_data, 32'h10 + i); else passed++;
            total++; if (rd_out !== 5'(i + 1)) $display("FAIL stream_rd_%0d: got %0d want %0d", i, rd_out, i + 1); else passed++;
            total++; if (in_ready !== 1'b1) $display("FAIL stream_in_ready_%0d: got %b want 1", i, in_ready); else passed++;
        end
        in_valid = 1'b0;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL stream_drain: got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        offer(32'hAAAA, 32'h1, 32'h0, 5'd6, 1'b1, 2'd1);
        step();
        total++; if (wb_data !== 32'hAAAA || in_ready !== 1'b1) $display("FAIL bp_a: got d=%h rdy=%b want d=aaaa rdy=1", wb_data, in_ready); else passed++;
        offer(32'hBBBB, 32'h2, 32'h0, 5'd7, 1'b1, 2'd1);
        step();
        total++; if (wb_data !== 32'hAAAA || in_ready !== 1'b0) $display("FAIL bp_b: got d=%h rdy=%b want d=aaaa rdy=0", wb_data, in_ready); else passed++;
        offer(32'hCCCC, 32'h3, 32'h0, 5'd8, 1'b1, 2'd1);
        step();
        total++; if (wb_data !== 32'hAAAA || in_ready !== 1'b0) $display("FAIL bp_hold: got d=%h rdy=%b want d=aaaa rdy=0", wb_data, in_ready); else passed++;
        out_ready = 1'b1;
        step();
        total++; if (wb_data !== 32'hBBBB || out_valid !== 1'b1 || in_ready !== 1'b1) $display("FAIL bp_out_b: got d=%h v=%b rdy=%b want d=bbbb v=1 rdy=1", wb_data, out_valid, in_ready); else passed++;
        step();
        in_valid = 1'b0;
        total++; if (wb_data !== 32'hCCCC || out_valid !== 1'b1) $display("FAIL bp_out_c: got d=%h v=%b want d=cccc v=1", wb_data, out_valid); else passed++;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL bp_drain: got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        offer(32'hEEEE, 32'h0, 32'h0, 5'd9, 1'b1, 2'd1);
        step();
        offer(32'hFFFF, 32'h0, 32'h0, 5'd10, 1'b1, 2'd1);
        step();
        total++; if (in_ready !== 1'b0) $display("FAIL flush_pre_full: got %b want 0", in_ready); else passed++;
        offer(32'hDDDD, 32'h0, 32'h0, 5'd11, 1'b1, 2'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL flush_after: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); else passed++;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (out_valid !== 1'b0) $display("FAIL flush_no_d_%0d: got v=%b d=%h want v=0", i, out_valid, wb_data); else passed++;
        end
    endtask

    task automatic test_mux();
        out_ready = 1'b0;
        offer(32'h66, 32'h55, 32'h104, 5'd5, 1'b1, 2'd2);
        step();
        total++; if (wb_data !== 32'h104 || wb_we !== 1'b1 || fwd_valid !== 1'b1) $display("FAIL mux_pc4: got d=%h we=%b fwd=%b want d=104 we=1 fwd=1", wb_data, wb_we, fwd_valid); else passed++;
        out_ready = 1'b1;
        offer(32'h66, 32'h55, 32'h104, 5'd0, 1'b1, 2'd2);
        step();
        total++; if (wb_data !== 32'h104 || wb_we !== 1'b0 || fwd_valid !== 1'b0) $display("FAIL mux_x0: got d=%h we=%b fwd=%b want d=104 we=0 fwd=0", wb_data, wb_we, fwd_valid); else passed++;
        offer(32'h66, 32'h55, 32'h104, 5'd7, 1'b1, 2'd3);
        step();
        total++; if (wb_data !== 32'h0 || wb_we !== 1'b1) $display("FAIL mux_sel3: got d=%h we=%b want d=0 we=1", wb_data, wb_we); else passed++;
        offer(32'h66, 32'h55, 32'h104, 5'd7, 1'b0, 2'd0);
        step();
        total++; if (wb_data !== 32'h55 || wb_we !== 1'b0) $display("FAIL mux_alu_nowrite: got d=%h we=%b want d=55 we=0", wb_data, wb_we); else passed++;
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        offer(32'h1111, 32'h0, 32'h0, 5'd3, 1'b1, 2'd1);
        step();
        offer(32'h2222, 32'h0, 32'h0, 5'd4, 1'b1, 2'd1);
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || wb_data !== 32'h1111) $display("FAIL rstmid_held: got v=%b d=%h want v=1 d=1111", out_valid, wb_data); else passed++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (out_valid !== 1'b0 || wb_we !== 1'b0 || in_ready !== 1'b1) $display("FAIL rstmid_after: got v=%b we=%b rdy=%b want 0/0/1", out_valid, wb_we, in_ready); else passed++;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (out_valid !== 1'b0) $display("FAIL rstmid_gone_%0d: got v=%b want 0", i, out_valid); else passed++;
        end
    endtask

    task automatic test_skid0();
        z_out_ready = 1'b0;
        z_in_valid = 1'b1;
        z_alu = 32'h20;
        step();
        total++; if (z_out_valid !== 1'b1 || z_in_ready !== 1'b0) $display("FAIL s0_stall: got v=%b rdy=%b want v=1 rdy=0", z_out_valid, z_in_ready); else passed++;
        z_out_ready = 1'b1;
        #1;
        total++; if (z_in_ready !== 1'b1) $display("FAIL s0_comb_ready: got %b want 1", z_in_ready); else passed++;
        for (int i = 0; i < 3; i++) begin
            z_alu = 32'h21 + i;
            step();
            total++; if (z_out_valid !== 1'b1 || z_wb_data !== 32'h21 + i) $display("FAIL s0_b2b_%0d: got v=%b d=%h want v=1 d=%h", i, z_out_valid, z_wb_data, 32'h21 + i); else passed++;
        end
        z_in_valid = 1'b0;
        step();
        total++; if (z_out_valid !== 1'b0) $display("FAIL s0_drain: got %b want 0", z_out_valid); else passed++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_mux();
        test_reset_mid();
        test_skid0();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_wb_skid_stage.md
Name: mem_wb_skid_stage

Overview:
- Parametrised successor to the fixed MEM/WB pipeline register, placed between the memory stage and the writeback/register-file port.
- Replaces the plain enable-based register with an elastic valid/ready stage, optionally backed by a one-entry skid buffer.
- Adds a synchronous flush and computes the writeback result in-stage.
- Drives the register-file write port and the hazard unit's MEM/WB forwarding inputs.

Parameters:
- DATAWIDTH, 32, width of memory data, ALU result, PC+4 and writeback data.
- REGINDEX, 5, width of destination register index.
- WBSELW, 2, width of writeback select field (must be >=2).
- SKID, 1, 1 = two-entry skid buffer (registered in_ready); 0 = single register, in_ready combinational from out_ready.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all held entries (synchronous).
- in_valid  in  1  upstream MEM stage holds a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- DataMEM_in  in  DATAWIDTH  load data from data memory.
- DataALU_in  in  DATAWIDTH  ALU result / address.
- PC4_in  in  DATAWIDTH  PC+4 for JAL/JALR link.
- regdindex_in  in  REGINDEX  destination register.
- regwrite_in  in  1  instruction writes rd.
- WBsel_in  in  WBSELW  writeback source select.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream (writeback) consumes head entry.
- wb_data  out  DATAWIDTH  selected writeback value of head entry.
- regdindex_out  out  REGINDEX  head entry rd.
- wb_we  out  1  register-file write enable.
- fwd_valid  out  1  head entry is a live forwarding source (equals wb_we).

Behaviour:
- Transfer in: in_valid & in_ready at the rising edge. Transfer out: out_valid & out_ready at the rising edge.
- Storage: main entry M (head), skid entry S (SKID=1 only). Each entry holds MEM, ALU, PC4, rd, regwrite and WBsel fields plus a valid bit.
- SKID=1 states (per valid bits):
  - EMPTY: M invalid. Accept -> FULL.
  - FULL: M valid, S invalid.
    - Accept with no out-transfer -> SKID (new entry goes to S).
    - Accept with out-transfer -> FULL (M replaced by the new entry).
    - Out-transfer only -> EMPTY.
  - SKID: both valid. Out-transfer -> FULL (S moves to M, S cleared). No accept is possible in this state.
  - in_ready = !S.valid, driven from a flop; no combinational path from out_ready.
- SKID=0:
  - in_ready = out_ready | !M.valid.
  - Accept loads M.
  - Out-transfer with no accept clears M.valid.
- Latency: 1 cycle from in-transfer to out_valid in EMPTY state. Throughput: 1 per cycle while out_ready is held high.
- Stall: out_ready low holds M unchanged. With SKID=1, exactly one further entry is absorbed before in_ready drops.
- Flush:
  - Next cycle, all valid bits are 0.
  - Flush overrides a same-cycle accept: the offered entry is dropped.
  - in_ready = 1 in the cycle after flush.
  - Payload fields need not be cleared.
- Reset: all valid bits 0. Payload fields 0. out_valid=0, wb_we=0, fwd_valid=0, in_ready=1 from the cycle after reset. Reset mid-operation discards all entries. rst has priority over flush and over transfers.
- Output mux, combinational from M:
  - WBsel 0 -> ALU.
  - WBsel 1 -> MEM.
  - WBsel 2 -> PC4.
  - Any other value -> 0.
- wb_data is driven even when out_valid=0; consumers gate it with out_valid.
- wb_we = out_valid & M.regwrite & (M.rd != 0); fwd_valid = wb_we. wb_we is not gated by out_ready; the register file writes when out_valid & out_ready.
- No data loss or duplication under any in_ready/out_ready interleaving.

Decomposition:
- Shared package (pipeline package):
  - WBsel encodings WB_ALU=0, WB_MEM=1, WB_PC4=2.
  - DATAWIDTH/REGINDEX defaults.
  - Packed struct mem_wb_payload_t {mem, alu, pc4, rd, regwrite, wbsel}.
- One natural sub-module: pipe_skid_buffer, a generic valid/ready skid buffer over a payload of parameter width with flush. This block instantiates it and adds the writeback mux and wb_we logic.

Test Plan:
- Reset then stream: rst 1 cycle; send 4 entries with ALU=0x10..0x13, WBsel=0, rd=1..4, out_ready=1 -> wb_data 0x10..0x13 on consecutive cycles starting 1 cycle after first accept; in_ready stays 1.
- Backpressure (SKID=1): out_ready=0, offer A(MEM=0xAAAA, WBsel=1), then B, then C -> A and B are accepted, and in_ready=0 from the cycle after B is accepted. Raise out_ready -> wb_data 0xAAAA, then B, then C, in order with no loss.
- Flush collision: state SKID, assert flush with in_valid=1 carrying D -> next cycle out_valid=0, in_ready=1; D is never output.
- Writeback mux and x0: entry with PC4=0x104, WBsel=2, rd=5, regwrite=1 -> wb_data=0x104, wb_we=1. Same entry with rd=0 -> wb_we=0. WBsel=3 -> wb_data=0.
- Reset mid-stall: two entries held with out_ready=0; assert rst -> next cycle out_valid=0, wb_we=0, in_ready=1; no held entry appears afterward.
- SKID=0 build: out_ready=0 with M valid -> in_ready=0 in the same cycle. out_ready=1 with in_valid=1 -> back-to-back transfer, 1 per cycle.
